// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Contents:
//   lsu_state_e - transaction FSM states
//   MASK_*      - byte-mask encodings used by mem_read / mem_write
//   mask_legal  - 1 when a mask is one of B/H/W and naturally aligned
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] offset);
    logic ok;
    case (mask)
      MASK_B:  ok = 1'b1;
      MASK_H:  ok = (offset[0] == 1'b0);
      MASK_W:  ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   st_mask_i, st_offset_i, st_wdata_i - store mask, byte offset, right-justified data
//   st_wdata_o, st_be_o                - lane-replicated store data and byte enables
//   ld_mask_i, ld_offset_i, ld_sign_i  - registered load controls
//   ld_rdata_i                         - full read word from the bus
//   ld_data_o                          - shifted, masked and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  st_mask_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  input  logic [3:0]  ld_mask_i,
  input  logic [1:0]  ld_offset_i,
  input  logic        ld_sign_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be_o = st_mask_i << st_offset_i;
    case (st_mask_i)
      MASK_B:  st_wdata_o = {4{st_wdata_i[7:0]}};
      MASK_H:  st_wdata_o = {2{st_wdata_i[15:0]}};
      default: st_wdata_o = st_wdata_i;
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_offset_i, 3'b000};
    case (ld_mask_i)
      MASK_B:  ld_data_o = {{24{ld_sign_i & ld_shifted[7]}}, ld_shifted[7:0]};
      MASK_H:  ld_data_o = {{16{ld_sign_i & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: validates the decoded access, issues one
// byte-enabled request on the data bus, waits for the handshake (and the read
// response for loads, bounded by TIMEOUT_CYCLES) and returns the extended
// load result. The pipeline is stalled for the whole transaction.
// Ports:
//   clk, rst_n                                 - clock, async active-low reset
//   mem_read, mem_write, mem_sign_extend       - decoded access controls
//   mem_addr, mem_wdata                        - effective address, store data
//   lsu_stall, ld_data, ld_valid               - pipeline interface
//   access_err, timeout_err                    - one-cycle error pulses
//   bus_req_valid/ready, bus_we, bus_addr,
//   bus_be, bus_wdata                          - request channel
//   bus_rsp_valid, bus_rsp_data                - read response channel
//
// state | meaning
// IDLE  | waiting for an access; illegal ones pulse access_err here
// REQ   | request presented, fields held until bus_req_ready
// RESP  | load accepted, waiting for bus_rsp_valid or timeout
// DONE  | result visible, pipeline released for one cycle
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        mem_read,
  input  logic [3:0]        mem_write,
  input  logic              mem_sign_extend,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              lsu_stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              access_err,
  output logic              timeout_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [3:0]        ld_mask_q, ld_mask_d;
  logic              ld_sign_q, ld_sign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;

  logic              access;
  logic              illegal;
  logic [3:0]        acc_mask;
  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] ld_ext;

  // Only one of the masks is nonzero for a legal access, so OR-ing them
  // yields the access mask used for lanes and alignment.
  assign acc_mask = mem_read | mem_write;
  assign access   = (mem_read != MASK_NONE) || (mem_write != MASK_NONE);
  assign illegal  = access &&
                    (((mem_read != MASK_NONE) && (mem_write != MASK_NONE)) ||
                     !mask_legal(acc_mask, mem_addr[1:0]));

  lsu_align u_align (
    .st_mask_i   (acc_mask),
    .st_offset_i (mem_addr[1:0]),
    .st_wdata_i  (mem_wdata),
    .st_wdata_o  (st_wdata),
    .st_be_o     (st_be),
    .ld_mask_i   (ld_mask_q),
    .ld_offset_i (ld_off_q),
    .ld_sign_i   (ld_sign_q),
    .ld_rdata_i  (bus_rsp_data),
    .ld_data_o   (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ld_off_q  <= '0;
      ld_mask_q <= '0;
      ld_sign_q <= 1'b0;
      cnt_q     <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ld_off_q  <= ld_off_d;
      ld_mask_q <= ld_mask_d;
      ld_sign_q <= ld_sign_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    be_d          = be_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    ld_off_d      = ld_off_q;
    ld_mask_d     = ld_mask_q;
    ld_sign_d     = ld_sign_q;
    cnt_d         = cnt_q;
    ld_data_d     = ld_data_q;
    lsu_stall     = 1'b0;
    access_err    = 1'b0;
    timeout_err   = 1'b0;
    bus_req_valid = 1'b0;
    ld_valid      = 1'b0;

    case (state_q)
      IDLE: begin
        if (illegal) begin
          access_err = 1'b1;
        end else if (access) begin
          lsu_stall = 1'b1;
          addr_d    = {mem_addr[ADDR_W-1:2], 2'b00};
          be_d      = st_be;
          we_d      = (mem_write != MASK_NONE);
          wdata_d   = st_wdata;
          ld_off_d  = mem_addr[1:0];
          ld_mask_d = acc_mask;
          ld_sign_d = mem_sign_extend;
          state_d   = REQ;
        end
      end
      REQ: begin
        lsu_stall     = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = we_q ? DONE : RESP;
        end
      end
      RESP: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // A response on the last allowed cycle takes priority over timeout.
        if (bus_rsp_valid) begin
          ld_data_d = ld_ext;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err = 1'b1;
          ld_data_d   = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        ld_valid = !we_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_read, mem_write;
  logic        mem_sign_extend;
  logic [31:0] mem_addr, mem_wdata;
  logic        lsu_stall, ld_valid, access_err, timeout_err;
  logic [31:0] ld_data;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_sign_extend(mem_sign_extend),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .lsu_stall(lsu_stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .access_err(access_err), .timeout_err(timeout_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
  );

  int checks = 0;
  int failures = 0;

  // Model: last registered bus fields and load result as seen by the pipeline.
  logic [31:0] m_addr, m_wdata, m_ld;
  logic [3:0]  m_be;
  logic        m_we;

  // Expected outputs for the current cycle.
  bit          exp_en;
  logic        e_stall, e_req, e_ldv, e_aerr, e_terr, e_we;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_be;

  logic [3:0] mask_tbl [3] = '{4'h1, 4'h3, 4'hF};

  function automatic int nbytes_of(input logic [3:0] m);
    if (m == 4'hF) return 4;
    if (m == 4'h3) return 2;
    if (m == 4'h1) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be_of(input int nb, input int off);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + nb);
    return r;
  endfunction

  function automatic logic [31:0] m_repl(input logic [31:0] wd, input int nb);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] rsp, input int off,
                                            input int nb, input bit sx);
    logic [31:0] v;
    v = rsp >> (8 * off);
    if (nb == 1) begin
      v = v & 32'h0000_00FF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = v & 32'h0000_FFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      chk("lsu_stall", lsu_stall, e_stall);
      chk("bus_req_valid", bus_req_valid, e_req);
      chk("ld_valid", ld_valid, e_ldv);
      chk("access_err", access_err, e_aerr);
      chk("timeout_err", timeout_err, e_terr);
      chk("ld_data", ld_data, e_ld);
      chk("bus_we", bus_we, e_we);
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_be", bus_be, e_be);
      chk("bus_wdata", bus_wdata, e_wdata);
    end
  end

  task automatic expect_cyc(input bit st, input bit rq, input bit lv, input bit ae, input bit te);
    e_stall = st; e_req = rq; e_ldv = lv; e_aerr = ae; e_terr = te;
    e_ld = m_ld; e_we = m_we; e_addr = m_addr; e_be = m_be; e_wdata = m_wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = '0; mem_write = '0; mem_sign_extend = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0;
  endtask

  task automatic drive_spur(input bit spur);
    if (spur) begin
      bus_rsp_valid = 1'($urandom_range(0, 1));
      bus_rsp_data  = $urandom;
    end else begin
      bus_rsp_valid = 1'b0;
    end
  endtask

  // One pipeline access from issue to release, expected outputs derived from
  // the access rules and the handshake latencies chosen for this call.
  task automatic run_txn(input logic [3:0] rd, input logic [3:0] wr, input bit sx,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_lat, input int rsp_lat,
                         input logic [31:0] rsp_word, input bit spur);
    logic [3:0] msk;
    int nb, off;
    bit legal, is_wr;
    msk   = rd | wr;
    nb    = nbytes_of(msk);
    off   = int'(addr[1:0]);
    legal = ((rd == 0) || (wr == 0)) && (nb != 0) && ((off % (nb == 0 ? 1 : nb)) == 0);
    is_wr = (wr != 0);
    mem_read = rd; mem_write = wr; mem_sign_extend = sx;
    mem_addr = addr; mem_wdata = wdata; bus_req_ready = 1'b0;
    drive_spur(spur);
    if (msk == 0) begin
      expect_cyc(0, 0, 0, 0, 0); step(); clear_inputs(); return;
    end
    if (!legal) begin
      expect_cyc(0, 0, 0, 1, 0); step(); clear_inputs(); return;
    end
    expect_cyc(1, 0, 0, 0, 0); step();
    m_addr  = {addr[31:2], 2'b00};
    m_be    = m_be_of(nb, off);
    m_we    = is_wr;
    m_wdata = m_repl(wdata, nb);
    for (int i = 0; i <= rdy_lat; i++) begin
      bus_req_ready = (i == rdy_lat);
      drive_spur(spur);
      expect_cyc(1, 1, 0, 0, 0); step();
    end
    bus_req_ready = 1'b0;
    if (!is_wr) begin
      for (int k = 0; k < TO; k++) begin
        bus_rsp_valid = (k == rsp_lat);
        bus_rsp_data  = (k == rsp_lat) ? rsp_word : $urandom;
        expect_cyc(1, 0, 0, 0, (k == TO - 1) && (k != rsp_lat)); step();
        if (k == rsp_lat) begin
          m_ld = m_extract(rsp_word, off, nb, sx);
          break;
        end
        if (k == TO - 1) m_ld = '0;
      end
    end
    drive_spur(spur);
    expect_cyc(0, 0, !is_wr, 0, 0); step();
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  msk, rd, wr;
    logic [31:0] a;
    int kind;
    rst_n = 1'b0;
    clear_inputs();
    m_addr = '0; m_wdata = '0; m_ld = '0; m_be = '0; m_we = 1'b0;
    expect_cyc(0, 0, 0, 0, 0);
    exp_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Model pins against hand-computed values.
    chk("pin_lbs", m_extract(32'h80112233, 3, 1, 1), 32'hFFFF_FF80);
    chk("pin_lb", m_extract(32'h80112233, 3, 1, 0), 32'h0000_0080);
    chk("pin_lhs", m_extract(32'h8001_7F00, 2, 2, 1), 32'hFFFF_8001);
    chk("pin_repl_h", m_repl(32'h0000_ABCD, 2), 32'hABCD_ABCD);
    chk("pin_be_h2", {28'd0, m_be_of(2, 2)}, 32'h0000_000C);

    run_txn(4'hF, 4'h0, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
    chk("lw_data", ld_data, 32'hDEADBEEF);
    chk("lw_addr", bus_addr, 32'h100);
    chk("lw_be", {28'd0, bus_be}, 32'hF);
    run_txn(4'h1, 4'h0, 1, 32'h203, 32'h0, 0, 0, 32'h80112233, 0);
    chk("lbs_data", ld_data, 32'hFFFF_FF80);
    chk("lbs_be", {28'd0, bus_be}, 32'h8);
    run_txn(4'h1, 4'h0, 0, 32'h203, 32'h0, 0, 0, 32'h80112233, 0);
    chk("lb_data", ld_data, 32'h0000_0080);
    run_txn(4'h0, 4'h3, 0, 32'h102, 32'h0000ABCD, 3, 0, 32'h0, 1);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh_be", {28'd0, bus_be}, 32'hC);
    chk("sh_we", {31'd0, bus_we}, 32'h1);
    chk("sh_ld_kept", ld_data, 32'h0000_0080);
    run_txn(4'h3, 4'h0, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0);
    run_txn(4'h7, 4'h0, 0, 32'h100, 32'h0, 0, 0, 32'h0, 0);
    run_txn(4'hF, 4'h3, 0, 32'h100, 32'h0, 0, 0, 32'h0, 0);
    run_txn(4'hF, 4'h0, 0, 32'h300, 32'h0, 0, 99, 32'h0, 0);
    chk("timeout_data", ld_data, 32'h0);
    run_txn(4'hF, 4'h0, 0, 32'h304, 32'h0, 1, TO - 1, 32'h12345678, 0);
    chk("late_rsp_data", ld_data, 32'h1234_5678);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      msk  = (kind == 0) ? 4'($urandom_range(0, 15)) : mask_tbl[$urandom_range(0, 2)];
      if ($urandom_range(0, 1) == 1) begin rd = msk; wr = '0; end
      else begin rd = '0; wr = msk; end
      if (kind == 1) begin rd = msk; wr = mask_tbl[$urandom_range(0, 2)]; end
      a = $urandom;
      if (kind >= 4) a[1:0] = (nbytes_of(msk) == 2) ? {a[1], 1'b0} :
                              (nbytes_of(msk) == 4) ? 2'b00 : a[1:0];
      if (kind == 9) begin rd = '0; wr = '0; end
      run_txn(rd, wr, 1'($urandom_range(0, 1)), a, $urandom,
              $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom,
              1'($urandom_range(0, 1)));
    end

    // Reset during RESP abandons the load; late responses are ignored.
    mem_read = 4'hF; mem_addr = 32'h440; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    expect_cyc(1, 0, 0, 0, 0); step();
    m_addr = 32'h440; m_be = 4'hF; m_we = 1'b0; m_wdata = mem_wdata;
    bus_req_ready = 1'b1;
    expect_cyc(1, 1, 0, 0, 0); step();
    bus_req_ready = 1'b0;
    expect_cyc(1, 0, 0, 0, 0); step();
    #1;
    rst_n = 1'b0;
    clear_inputs();
    m_addr = '0; m_wdata = '0; m_ld = '0; m_be = '0; m_we = 1'b0;
    expect_cyc(0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = $urandom;
      step();
    end
    clear_inputs();
    step();
    chk("post_reset_ld", ld_data, 32'h0);

    exp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
